// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot controller for the cpu instruction memory. A program image arrives as a
// byte stream (valid/ready): LEN_LO, LEN_HI (16-bit word count N), then 4*N
// payload bytes, least-significant byte first. Each assembled 32-bit word is
// written to the imem write port starting at word address 0. The cpu is held
// in reset (cpu_rst_n=0) until the whole image has been written.
//
// Optional feature (compile-time macro CHECKSUM_EN):
//   When defined, one trailing byte follows the payload. It must equal the
//   XOR of LEN_LO, LEN_HI and every payload byte, otherwise the image is
//   rejected (ERR). When undefined there is no trailing byte.
//
// Parameters:
//   ADDR_W    imem word-address width
//   DEPTH     imem capacity in words; largest accepted N (DEPTH <= 2**ADDR_W)
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, begin (re)load from any state
//   rx_data    in   [7:0] image byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts a byte this cycle (taken on valid && ready)
//   im_en      out  imem write strobe, one pulse per word
//   im_addr    out  [ADDR_W-1:0] imem word address
//   im_wdata   out  [31:0] imem write data
//   cpu_rst_n  out  active-low cpu reset, registered, high only in RUN
//   busy       out  load in progress
//   done       out  image loaded, cpu running
//   err        out  image rejected, cpu held in reset
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef CHECKSUM_EN
        S_CHK,
`endif
        S_FIN,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] WORD_ONE = 1;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    // One bit wider than the address so that N == 2**ADDR_W can be counted.
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic              acc;
    logic [15:0]       n_full;
    logic [16:0]       cnt_nxt;
    logic              last_word;
`ifdef CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // A byte is taken only when no start competes for the same cycle.
    assign acc = rx_valid && rx_ready && !start;

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_LEN0, S_LEN1, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_FIN:   busy = 1'b1;
            S_RUN:   done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        n_full    = {rx_data, len_lo};
        cnt_nxt   = 17'(word_idx) + 17'd1;
        last_word = (cnt_nxt == {1'b0, len});
        if (start) begin
            state_nxt = S_LEN0;
        end else begin
            case (state)
                S_IDLE: ;
                S_LEN0: if (acc) state_nxt = S_LEN1;
                S_LEN1: begin
                    if (acc) begin
                        if ({1'b0, n_full} > 17'(DEPTH)) begin
                            state_nxt = S_ERR;
                        end else if (n_full == 16'd0) begin
`ifdef CHECKSUM_EN
                            state_nxt = S_CHK;
`else
                            state_nxt = S_FIN;
`endif
                        end else begin
                            state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (acc && byte_idx == 2'd3 && last_word) begin
`ifdef CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_FIN;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_CHK: begin
                    if (acc) state_nxt = (rx_data == csum) ? S_FIN : S_ERR;
                end
`endif
                S_FIN:   state_nxt = S_RUN;
                S_RUN:   ;
                S_ERR:   ;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath: length capture, word assembly, write strobe and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo    <= '0;
            len       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            im_en     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_rst_n <= 1'b0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            im_en     <= 1'b0;
            // Registered release: high exactly while the FSM sits in RUN.
            cpu_rst_n <= (state_nxt == S_RUN);
            if (start) begin
                // Restart drops any partial word; already written words stay.
                word_idx <= '0;
                byte_idx <= '0;
`ifdef CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (acc) begin
`ifdef CHECKSUM_EN
                csum <= csum ^ rx_data;
`endif
                case (state)
                    S_LEN0: len_lo <= rx_data;
                    S_LEN1: begin
                        len      <= {rx_data, len_lo};
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                    S_DATA: begin
                        case (byte_idx)
                            2'd0:    im_wdata[7:0]   <= rx_data;
                            2'd1:    im_wdata[15:8]  <= rx_data;
                            2'd2:    im_wdata[23:16] <= rx_data;
                            default: im_wdata[31:24] <= rx_data;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            im_en    <= 1'b1;
                            im_addr  <= word_idx[ADDR_W-1:0];
                            word_idx <= word_idx + WORD_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_en;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .im_en     (im_en),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [31:0] base;
        bit          gaps;
        bit          exp_err;
    } vec_t;

    vec_t                   vecs [7];
    logic [31:0]            wbuf [0:DEPTH-1];
    logic [ADDR_W+31:0]     exp_q [$];
    int                     n_vec = 0;
    int                     n_miss = 0;
    int                     stall_cnt;
    logic [7:0]             csum_tb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; sample #1 after the edge and score any imem write.
    task automatic tick();
        logic [ADDR_W+31:0] e;
        @(posedge clk);
        #1;
        if (im_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL spurious_im_en: addr %0d data 0x%08h, want no write", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                check("im_addr", 32'(im_addr), 32'(e[ADDR_W+31:32]));
                check("im_wdata", im_wdata, e[31:0]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit got;
        if (gap) begin
            rx_valid = 1'b0;
            tick();
        end
        csum_tb  = csum_tb ^ b;
        rx_data  = b;
        rx_valid = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            got = rx_ready;
            tick();
            if (!got) stall_cnt++;
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL rx_ready_timeout: byte 0x%02h not taken, want accepted", b);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("start_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic load_image(input logic [15:0] n, input bit gaps, input bit exp_err, input bit do_start);
        logic [31:0] w;
        logic [7:0]  bad;
        if (do_start) pulse_start();
        csum_tb   = 8'h00;
        stall_cnt = 0;
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        if (exp_err) begin
            check("len_err", 32'(err), 32'd1);
            check("len_err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            check("len_err_rx_ready", 32'(rx_ready), 32'd0);
            check("len_err_busy", 32'(busy), 32'd0);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = wbuf[i];
                for (int b = 0; b < 4; b++) begin
                    if (b == 3) exp_q.push_back({ADDR_W'(i), w});
                    send_byte(w[8*b +: 8], gaps);
                end
            end
`ifdef CHECKSUM_EN
            bad = csum_tb;
            send_byte(bad, gaps);
`else
            bad = 8'h00;
`endif
            check("fin_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            check("fin_busy", 32'(busy), 32'd1);
            tick();
            check("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
            check("run_done", 32'(done), 32'd1);
            check("run_busy", 32'(busy), 32'd0);
            check("run_err", 32'(err), 32'd0);
            check("writes_pending", 32'(exp_q.size()), 32'd0);
            if (!gaps) check("stall_cycles", 32'(stall_cnt), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{16'd1,      32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{16'd513,    32'h00000000, 1'b0, 1'b1};
        vecs[2] = '{16'd3,      32'h12345678, 1'b1, 1'b0};
        vecs[3] = '{16'd0,      32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF,   32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{16'd512,    32'hA5A50F0F, 1'b0, 1'b0};
        vecs[6] = '{16'd5,      32'h0BADF00D, 1'b1, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        csum_tb  = 8'h00;
        stall_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_im_en", 32'(im_en), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // IDLE ignores bytes
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) tick();
        rx_valid = 1'b0;
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Two-word image, back-to-back bytes
        wbuf[0] = 32'h00308133;
        wbuf[1] = 32'h006203B3;
        load_image(16'd2, 1'b0, 1'b0, 1'b1);

        // Same image with rx_valid gaps, restarted from RUN
        load_image(16'd2, 1'b1, 1'b0, 1'b1);

        // RUN ignores bytes
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) tick();
        rx_valid = 1'b0;
        check("run_hold_done", 32'(done), 32'd1);
        check("run_hold_rx_ready", 32'(rx_ready), 32'd0);

        // Abort mid-word; start coincides with an offered byte
        pulse_start();
        csum_tb = 8'h00;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_rx_ready", 32'(rx_ready), 32'd1);
        load_image(16'd2, 1'b0, 1'b0, 1'b0);

        // Table of images
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < DEPTH; i++) wbuf[i] = vecs[v].base + 32'(i) * 32'h01030507;
            load_image(vecs[v].n, vecs[v].gaps, vecs[v].exp_err, 1'b1);
        end

`ifdef CHECKSUM_EN
        // Wrong trailing checksum: the word is still written, image rejected
        begin
            logic [7:0] bad;
            pulse_start();
            csum_tb = 8'h00;
            exp_q.push_back({ADDR_W'(0), 32'hCAFEF00D});
            send_byte(8'h01, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h0D, 1'b0);
            send_byte(8'hF0, 1'b0);
            send_byte(8'hFE, 1'b0);
            send_byte(8'hCA, 1'b0);
            bad = csum_tb ^ 8'h01;
            send_byte(bad, 1'b0);
            check("csum_err", 32'(err), 32'd1);
            check("csum_err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
            check("csum_err_writes", 32'(exp_q.size()), 32'd0);
        end
`endif

        // Asynchronous reset from RUN drops cpu_rst_n immediately
        wbuf[0] = 32'h13579BDF;
        load_image(16'd1, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        #10;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
